// File: rtl/temp2lcd_pkg.sv
// rtl/temp2lcd_pkg.sv - shared constants and helpers for the temperature-to-LCD formatter
//
// Purpose: state encoding, ASCII constants, double-dabble sizing and the
//          nibble-correction helper used by bin2bcd_dd and temp2lcd_fmt.
// Ports:   none (package).
package temp2lcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCALE = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_BLANK = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    localparam int BIN_W    = 11;
    localparam int BCD_W    = 16;
    localparam int BCD_ITER = 11;

    // Largest tenths-of-degree magnitude shown for a negative reading.
    localparam logic [BIN_W-1:0] NEG_CLAMP = 11'd999;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
        return ASCII_ZERO + {4'b0000, nib};
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - iterative 11-bit binary to 4-digit BCD converter (shift-add-3)
//
// Purpose: loads bin_i on start_i, then performs one shift-add-3 iteration per
//          cycle for BCD_ITER cycles.
// Ports:   sys_clk, rstn     clock, asynchronous active-low reset
//          start_i           load bin_i and clear the BCD accumulator
//          bin_i   [10:0]    binary value to convert
//          done_o            high during the final iteration cycle; bcd_o holds
//                            the finished result from the following cycle on
//          bcd_o   [15:0]    BCD result, nibble 0 least significant
module bin2bcd_dd
    import temp2lcd_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    localparam logic [3:0] LAST_CNT = 4'(BCD_ITER - 1);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [3:0]       cnt_q;
    logic             busy_q;

    // Combinational so the caller can leave its wait state on the same edge
    // that performs the last shift.
    assign done_o = busy_q && (cnt_q == LAST_CNT);
    assign bcd_o  = bcd_q;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {add3_nibbles(bcd_q), bin_q} << 1;
            cnt_q          <= cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/temp2lcd_fmt.sv
// rtl/temp2lcd_fmt.sv - 12-bit sensor temperature to 4-character LCD formatter
//
// Purpose: accepts one signed 1/16 degC reading per conversion, scales it to
//          tenths of a degree, converts to BCD and writes four ASCII characters
//          plus decimal-point pattern on a single edge.
// Ports:   sys_clk, rstn          clock, asynchronous active-low reset
//          in_valid_i             temp_data_i is valid
//          in_ready_o             high only while idle
//          temp_data_i [11:0]     two's-complement reading, 1/16 degC per LSB
//          lcd_digit0_o..3 [7:0]  ASCII characters, left to right
//          lcd_decpt0_o..2        decimal point after digit 0/1/2
//          lcd_colon_o            colon, always low
//          out_update_o           one-cycle pulse after the display is rewritten
module temp2lcd_fmt
    import temp2lcd_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [11:0] temp_data_i,
    output logic [7:0]  lcd_digit0_o,
    output logic [7:0]  lcd_digit1_o,
    output logic [7:0]  lcd_digit2_o,
    output logic [7:0]  lcd_digit3_o,
    output logic        lcd_decpt0_o,
    output logic        lcd_decpt1_o,
    output logic        lcd_decpt2_o,
    output logic        lcd_colon_o,
    output logic        out_update_o
);

    logic [1:0]       state_q, state_d;
    logic             sign_q;
    logic [11:0]      mag_q;
    logic [7:0]       digit0_q, digit1_q, digit2_q, digit3_q;
    logic             decpt0_q, decpt1_q, decpt2_q, colon_q;
    logic             out_update_q;

    logic             accept;
    logic [13:0]      mag_x5;
    logic [BIN_W-1:0] tenths_raw, tenths;
    logic             conv_last;
    logic [BCD_W-1:0] bcd;
    logic [3:0]       nib_hund, nib_tens, nib_ones, nib_tenth;

    assign in_ready_o = (state_q == ST_IDLE);
    assign accept     = in_valid_i && in_ready_o;

    // 1/16 degC -> 1/10 degC is *10/16 = *5/8, truncated. The magnitude of
    // 0x800 is 2048, which still fits the 12-bit mag and 14-bit product.
    assign mag_x5     = {mag_q, 2'b00} + {2'b00, mag_q};
    assign tenths_raw = 11'(mag_x5 >> 3);
    assign tenths     = (sign_q && (tenths_raw > NEG_CLAMP)) ? NEG_CLAMP : tenths_raw;

    bin2bcd_dd u_bin2bcd (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .start_i (state_q == ST_SCALE),
        .bin_i   (tenths),
        .done_o  (conv_last),
        .bcd_o   (bcd)
    );

    // The value is in tenths, so BCD nibble 0 is the tenths digit.
    assign nib_tenth = bcd[3:0];
    assign nib_ones  = bcd[7:4];
    assign nib_tens  = bcd[11:8];
    assign nib_hund  = bcd[15:12];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SCALE;
            ST_SCALE: state_d = ST_CONV;
            ST_CONV:  if (conv_last) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            digit0_q     <= ASCII_MINUS;
            digit1_q     <= ASCII_MINUS;
            digit2_q     <= ASCII_MINUS;
            digit3_q     <= ASCII_MINUS;
            decpt0_q     <= 1'b0;
            decpt1_q     <= 1'b0;
            decpt2_q     <= 1'b0;
            colon_q      <= 1'b0;
            out_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_update_q <= 1'b0;
            if (accept) begin
                sign_q <= temp_data_i[11];
                mag_q  <= temp_data_i[11] ? (~temp_data_i + 12'd1) : temp_data_i;
            end
            if (state_q == ST_DONE) begin
                digit3_q     <= ascii_digit(nib_tenth);
                digit2_q     <= ascii_digit(nib_ones);
                digit1_q     <= (nib_tens == 4'd0 && nib_hund == 4'd0) ? ASCII_BLANK
                                                                       : ascii_digit(nib_tens);
                if (sign_q) begin
                    digit0_q <= ASCII_MINUS;
                end else begin
                    digit0_q <= (nib_hund == 4'd0) ? ASCII_BLANK : ascii_digit(nib_hund);
                end
                decpt0_q     <= 1'b0;
                decpt1_q     <= 1'b0;
                decpt2_q     <= 1'b1;
                colon_q      <= 1'b0;
                out_update_q <= 1'b1;
            end
        end
    end

    assign lcd_digit0_o = digit0_q;
    assign lcd_digit1_o = digit1_q;
    assign lcd_digit2_o = digit2_q;
    assign lcd_digit3_o = digit3_q;
    assign lcd_decpt0_o = decpt0_q;
    assign lcd_decpt1_o = decpt1_q;
    assign lcd_decpt2_o = decpt2_q;
    assign lcd_colon_o  = colon_q;
    assign out_update_o = out_update_q;

endmodule

// File: tb/tb_temp2lcd_fmt.sv
// tb/tb_temp2lcd_fmt.sv - directed self-checking bench for temp2lcd_fmt
module tb_temp2lcd_fmt;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] temp_data = '0;
    logic        in_ready;
    logic [7:0]  d0, d1, d2, d3;
    logic        dp0, dp1, dp2, colon, out_update;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    temp2lcd_fmt dut (
        .sys_clk      (sys_clk),
        .rstn         (rstn),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .temp_data_i  (temp_data),
        .lcd_digit0_o (d0),
        .lcd_digit1_o (d1),
        .lcd_digit2_o (d2),
        .lcd_digit3_o (d3),
        .lcd_decpt0_o (dp0),
        .lcd_decpt1_o (dp1),
        .lcd_decpt2_o (dp2),
        .lcd_colon_o  (colon),
        .out_update_o (out_update)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One word through the handshake; checks latency and the displayed word.
    task automatic run_word(input logic [11:0] t, input logic [31:0] exp_digits, input string tag);
        int cyc;
        bit seen;
        @(negedge sys_clk);
        chk({tag, "_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        temp_data = t;
        @(negedge sys_clk);
        in_valid = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (out_update) seen = 1'b1;
            else begin
                @(negedge sys_clk);
                cyc++;
            end
        end
        chk({tag, "_latency"}, cyc, 32'd13);
        chk({tag, "_digits"}, {d0, d1, d2, d3}, exp_digits);
        chk({tag, "_decpt"}, {29'd0, dp2, dp1, dp0}, 32'b100);
        chk({tag, "_colon_ready"}, {30'd0, colon, in_ready}, 32'b01);
        @(negedge sys_clk);
        chk({tag, "_pulse_len"}, {31'd0, out_update}, 32'd0);
    endtask

    initial begin
        int pulses;
        int changes;
        int ready_low;
        logic [31:0] snap;
        logic [31:0] exp_seq [2];

        // Reset state, during and after reset
        #12;
        chk("rst_digits", {d0, d1, d2, d3}, "----");
        chk("rst_flags", {27'd0, dp2, dp1, dp0, in_ready, out_update}, 32'b00010);
        @(negedge sys_clk);
        rstn = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_digits", {d0, d1, d2, d3}, "----");
        chk("post_rst_flags", {27'd0, dp2, dp1, dp0, in_ready, out_update}, 32'b00010);

        run_word(12'h190, " 250", "p25_0");
        run_word(12'h1A6, " 263", "p26_3");
        run_word(12'hF38, "-125", "m12_5");
        run_word(12'hFF8, "- 05", "m0_5");
        run_word(12'h800, "-999", "clamp");
        run_word(12'h7FF, "1279", "max");
        run_word(12'h000, "  00", "zero");
        run_word(12'hFFF, "- 00", "negzero");

        // Back-to-back: valid held high with two words
        exp_seq[0] = " 250";
        exp_seq[1] = "-125";
        @(negedge sys_clk);
        snap      = {d0, d1, d2, d3};
        in_valid  = 1'b1;
        temp_data = 12'h190;
        @(negedge sys_clk);
        temp_data = 12'hF38;
        pulses    = 0;
        changes   = 0;
        ready_low = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 14 && !in_ready) ready_low++;
            if (cyc == 14) chk("b2b_second_accept", {31'd0, in_ready}, 32'd0);
            if (out_update) begin
                if (pulses < 2) begin
                    chk("b2b_pulse_cycle", cyc, (pulses == 0) ? 32'd13 : 32'd27);
                    chk("b2b_digits", {d0, d1, d2, d3}, exp_seq[pulses]);
                end
                pulses++;
                snap = {d0, d1, d2, d3};
            end else if ({d0, d1, d2, d3} !== snap) begin
                changes++;
                snap = {d0, d1, d2, d3};
            end
            @(negedge sys_clk);
            if (cyc == 13) in_valid = 1'b0;
        end
        chk("b2b_ready_low", ready_low, 32'd13);
        chk("b2b_pulses", pulses, 32'd2);
        chk("b2b_stable", changes, 32'd0);

        // Reset mid-conversion
        @(negedge sys_clk);
        in_valid  = 1'b1;
        temp_data = 12'h190;
        @(negedge sys_clk);
        in_valid  = 1'b0;
        temp_data = 12'h000;
        repeat (5) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_digits", {d0, d1, d2, d3}, "----");
        chk("abort_flags", {27'd0, dp2, dp1, dp0, in_ready, out_update}, 32'b00010);
        repeat (2) @(negedge sys_clk);
        rstn   = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge sys_clk);
            if (out_update) pulses++;
        end
        chk("abort_no_update", pulses, 32'd0);
        chk("abort_digits_held", {d0, d1, d2, d3}, "----");
        run_word(12'hF38, "-125", "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
